// File: rtl/nw_seq_aligner.sv
// Sequential Needleman-Wunsch aligner: fills the score matrix one cell per
// cycle from a two-row buffer, then streams the traceback path over valid/ready.
module nw_seq_aligner #(
  parameter int         MAX_LEN     = 16,
  parameter int         CWIDTH      = 2,
  parameter int         SWIDTH      = 16,
  parameter int         CORD_LENGTH = 8,
  parameter logic [1:0] TOP_DIR     = 2'b00,
  parameter logic [1:0] LEFT_DIR    = 2'b01,
  parameter logic [1:0] CORNER_DIR  = 2'b10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CORD_LENGTH-1:0]        len1,
  input  logic [CORD_LENGTH-1:0]        len2,
  input  logic [MAX_LEN*CWIDTH-1:0]     s1,
  input  logic [MAX_LEN*CWIDTH-1:0]     s2,
  input  logic signed [SWIDTH-1:0]      match,
  input  logic signed [SWIDTH-1:0]      mismatch,
  input  logic signed [SWIDTH-1:0]      indel,
  output logic                          busy,
  output logic                          err,
  output logic signed [SWIDTH-1:0]      score,
  output logic                          score_valid,
  output logic                          tb_valid,
  input  logic                          tb_ready,
  output logic [CORD_LENGTH-1:0]        tb_x,
  output logic [CORD_LENGTH-1:0]        tb_y,
  output logic [1:0]                    tb_op,
  output logic                          tb_last
);

  localparam int RW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int IW = $clog2(MAX_LEN + 1);

  typedef logic [CORD_LENGTH-1:0]   cord_t;
  typedef logic signed [SWIDTH-1:0] score_t;
  typedef enum logic [1:0] {IDLE, INIT, FILL, TRACE} state_t;

  state_t                           state_q;
  cord_t                            len1_q, len2_q, i_q, j_q;
  logic [MAX_LEN-1:0][CWIDTH-1:0]   s1_q, s2_q;
  score_t                           match_q, mismatch_q, indel_q;
  score_t                           prev_q [MAX_LEN+1];
  score_t                           cur_q  [MAX_LEN+1];
  logic [1:0]                       dir_q  [MAX_LEN][MAX_LEN];

  logic   err_q, score_valid_q, tb_valid_q, tb_last_q;
  score_t score_q;
  cord_t  tb_x_q, tb_y_q;
  logic [1:0] tb_op_q;

  logic len_ok, accept;
  assign len_ok = (len1 != '0) && (len1 <= cord_t'(MAX_LEN)) &&
                  (len2 != '0) && (len2 <= cord_t'(MAX_LEN));
  assign accept = (state_q == IDLE) && start && len_ok;

  // Fill-cell datapath
  logic [IW-1:0] jx, jm1;
  logic [RW-1:0] ri, rj;
  assign jx  = IW'(j_q);
  assign jm1 = IW'(j_q - 1'b1);
  assign ri  = RW'(i_q - 1'b1);
  assign rj  = RW'(j_q - 1'b1);

  score_t     diag, top, left, h;
  logic [1:0] op_fill;
  logic       row_end, last_cell;

  always_comb begin
    diag = prev_q[jm1] + ((s1_q[ri] == s2_q[rj]) ? match_q : mismatch_q);
    top  = prev_q[jx] + indel_q;
    left = cur_q[jm1] + indel_q;
    if (diag >= top && diag >= left) begin
      h = diag; op_fill = CORNER_DIR;
    end else if (top >= left) begin
      h = top;  op_fill = TOP_DIR;
    end else begin
      h = left; op_fill = LEFT_DIR;
    end
  end

  assign row_end   = (j_q == len2_q);
  assign last_cell = row_end && (i_q == len1_q);

  function automatic logic [2*CORD_LENGTH-1:0] step(input cord_t x, input cord_t y,
                                                    input logic [1:0] op);
    if (op == TOP_DIR)       return {x, y - 1'b1};
    else if (op == LEFT_DIR) return {x - 1'b1, y};
    else                     return {x - 1'b1, y - 1'b1};
  endfunction

  // Traceback lookahead: beat fields are registered, so the next cell and
  // whether it is the final one are resolved a beat ahead.
  cord_t      ent_nx, ent_ny, nx, ny, nnx, nny;
  logic [1:0] nop;
  logic       ent_last, nlast;

  always_comb begin
    {ent_nx, ent_ny} = step(len2_q, len1_q, op_fill);
    ent_last         = (ent_nx == '0) && (ent_ny == '0);
    {nx, ny}         = step(tb_x_q, tb_y_q, tb_op_q);
    if (ny == '0)      nop = LEFT_DIR;
    else if (nx == '0) nop = TOP_DIR;
    else               nop = dir_q[RW'(ny - 1'b1)][RW'(nx - 1'b1)];
    {nnx, nny}       = step(nx, ny, nop);
    nlast            = (nnx == '0) && (nny == '0);
  end

  // Score rows, direction RAM and latched run parameters need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      len1_q     <= len1;
      len2_q     <= len2;
      s1_q       <= s1;
      s2_q       <= s2;
      match_q    <= match;
      mismatch_q <= mismatch;
      indel_q    <= indel;
    end
    case (state_q)
      INIT: begin
        for (int k = 0; k <= MAX_LEN; k++)
          prev_q[IW'(k)] <= $signed(SWIDTH'(k)) * indel_q;
        cur_q[0] <= indel_q;
      end
      FILL: begin
        cur_q[jx]     <= h;
        dir_q[ri][rj] <= op_fill;
        if (row_end) begin
          for (int k = 0; k <= MAX_LEN; k++)
            prev_q[IW'(k)] <= (IW'(k) == jx) ? h : cur_q[IW'(k)];
          cur_q[0] <= cur_q[0] + indel_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      err_q         <= 1'b0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      tb_valid_q    <= 1'b0;
      tb_x_q        <= '0;
      tb_y_q        <= '0;
      tb_op_q       <= '0;
      tb_last_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              state_q       <= INIT;
              score_valid_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        INIT: begin
          i_q     <= cord_t'(1);
          j_q     <= cord_t'(1);
          state_q <= FILL;
        end
        FILL: begin
          if (row_end) begin
            j_q <= cord_t'(1);
            i_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
          if (last_cell) begin
            state_q       <= TRACE;
            score_q       <= h;
            score_valid_q <= 1'b1;
            tb_valid_q    <= 1'b1;
            tb_x_q        <= len2_q;
            tb_y_q        <= len1_q;
            tb_op_q       <= op_fill;
            tb_last_q     <= ent_last;
          end
        end
        TRACE: begin
          if (tb_ready) begin
            if (tb_last_q) begin
              state_q    <= IDLE;
              tb_valid_q <= 1'b0;
              tb_x_q     <= '0;
              tb_y_q     <= '0;
              tb_op_q    <= '0;
              tb_last_q  <= 1'b0;
            end else begin
              tb_x_q    <= nx;
              tb_y_q    <= ny;
              tb_op_q   <= nop;
              tb_last_q <= nlast;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign score       = score_q;
  assign score_valid = score_valid_q;
  assign tb_valid    = tb_valid_q;
  assign tb_x        = tb_x_q;
  assign tb_y        = tb_y_q;
  assign tb_op       = tb_op_q;
  assign tb_last     = tb_last_q;

endmodule

// File: tb/tb_nw_seq_aligner.sv
// Bench for nw_seq_aligner: directed and random alignments against a
// full-matrix reference model, with stalls, errors, resets and back-to-back runs.
module tb_nw_seq_aligner;
  localparam int ML = 16, CW = 2, SW = 16, CL = 8, SB = ML*CW;
  localparam int TD = 0, LD = 1, CD = 2;

  logic clk = 1'b0;
  logic reset, start, tb_ready;
  logic [CL-1:0] len1, len2;
  logic [SB-1:0] s1, s2;
  logic signed [SW-1:0] match, mismatch, indel;
  logic busy, err, score_valid, tb_valid, tb_last;
  logic signed [SW-1:0] score;
  logic [CL-1:0] tb_x, tb_y;
  logic [1:0] tb_op;

  int vecs = 0, fails = 0;
  int ex_x[$], ex_y[$], ex_op[$];
  int ex_score;

  always #5 clk = ~clk;

  nw_seq_aligner #(.MAX_LEN(ML), .CWIDTH(CW), .SWIDTH(SW), .CORD_LENGTH(CL)) dut (
    .clk(clk), .reset(reset), .start(start), .len1(len1), .len2(len2),
    .s1(s1), .s2(s2), .match(match), .mismatch(mismatch), .indel(indel),
    .busy(busy), .err(err), .score(score), .score_valid(score_valid),
    .tb_valid(tb_valid), .tb_ready(tb_ready), .tb_x(tb_x), .tb_y(tb_y),
    .tb_op(tb_op), .tb_last(tb_last));

  function automatic logic [SB-1:0] enc(input string s);
    logic [SB-1:0] v = '0;
    for (int k = 0; k < s.len(); k++)
      case (s[k])
        "C": v[k*CW +: CW] = 2'd1;
        "G": v[k*CW +: CW] = 2'd2;
        "T": v[k*CW +: CW] = 2'd3;
        default: v[k*CW +: CW] = 2'd0;
      endcase
    return v;
  endfunction

  // Full score matrix, then walk back re-deriving each cell's best predecessor.
  task automatic model(input int l1, input int l2, input logic [SB-1:0] a,
                       input logic [SB-1:0] b, input int m, input int mm, input int ind);
    int H[ML+1][ML+1];
    int D[ML+1][ML+1];
    int x, y, op, dg, tp, lf, best;
    for (int i = 0; i <= l1; i++) H[i][0] = i*ind;
    for (int j = 0; j <= l2; j++) H[0][j] = j*ind;
    for (int i = 1; i <= l1; i++)
      for (int j = 1; j <= l2; j++) begin
        dg = H[i-1][j-1] + ((a[(i-1)*CW +: CW] == b[(j-1)*CW +: CW]) ? m : mm);
        tp = H[i-1][j] + ind;
        lf = H[i][j-1] + ind;
        best = dg;
        if (tp > best) best = tp;
        if (lf > best) best = lf;
        H[i][j] = best;
        D[i][j] = (dg == best) ? CD : (tp == best) ? TD : LD;
      end
    ex_score = H[l1][l2];
    ex_x.delete(); ex_y.delete(); ex_op.delete();
    x = l2; y = l1;
    while (x > 0 || y > 0) begin
      op = (y == 0) ? LD : (x == 0) ? TD : D[y][x];
      ex_x.push_back(x); ex_y.push_back(y); ex_op.push_back(op);
      if (op == CD) begin x--; y--; end
      else if (op == TD) y--;
      else x--;
    end
  endtask

  task automatic drive_start(input int l1, input int l2, input logic [SB-1:0] a,
                             input logic [SB-1:0] b, input int m, input int mm, input int ind);
    len1 = CL'(l1); len2 = CL'(l2); s1 = a; s2 = b;
    match = SW'(m); mismatch = SW'(mm); indel = SW'(ind);
    start = 1'b1;
  endtask

  // stall: 0 = always ready, 1 = ready low 3 cycles per beat, 2 = random
  task automatic run_case(input string nm, input int l1, input int l2, input logic [SB-1:0] a,
                          input logic [SB-1:0] b, input int m, input int mm, input int ind,
                          input int stall, input bit b2b);
    int lat, nb, wcnt, guard;
    bit held, r, drop;
    logic [CL-1:0] hx, hy;
    logic [1:0] hop;
    logic hl;
    model(l1, l2, a, b, m, mm, ind);
    if (!b2b) @(negedge clk);
    drive_start(l1, l2, a, b, m, mm, ind);
    @(negedge clk);
    start = 1'b0;
    len1 = CL'($urandom_range(0, 20)); len2 = CL'($urandom_range(0, 20));
    s1 = SB'($urandom); s2 = SB'($urandom);
    match = SW'($urandom); mismatch = SW'($urandom); indel = SW'($urandom);
    vecs++;
    if (busy !== 1'b1) begin fails++; $display("FAIL %s busy: got %b want 1", nm, busy); end
    lat = 1;
    while (!tb_valid && lat < 400) begin
      if (lat == 2) start = 1'b1;
      @(negedge clk); lat++;
      if (lat == 3) begin
        start = 1'b0;
        vecs++;
        if (err !== 1'b0) begin fails++; $display("FAIL %s err_busy: got %b want 0", nm, err); end
      end
    end
    vecs++;
    if (lat != l1*l2 + 2) begin
      fails++; $display("FAIL %s latency: got %0d want %0d", nm, lat, l1*l2 + 2);
    end
    vecs++;
    if (score !== SW'(ex_score)) begin
      fails++; $display("FAIL %s score: got %0d want %0d", nm, score, ex_score);
    end
    vecs++;
    if (score_valid !== 1'b1) begin fails++; $display("FAIL %s score_valid: got %b want 1", nm, score_valid); end
    nb = 0; wcnt = 0; held = 0; guard = 0; drop = 0;
    while (nb < ex_x.size() && guard < 2000) begin
      if (held) begin
        vecs++;
        if ({tb_valid, tb_x, tb_y, tb_op, tb_last} !== {1'b1, hx, hy, hop, hl}) begin
          fails++;
          $display("FAIL %s stall_hold beat%0d: got x%0d y%0d op%0d last%0d want x%0d y%0d op%0d last%0d",
                   nm, nb, tb_x, tb_y, tb_op, tb_last, hx, hy, hop, hl);
        end
      end
      case (stall)
        0: r = 1'b1;
        1: r = (wcnt >= 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      tb_ready = r;
      vecs++;
      if (tb_valid !== 1'b1) begin
        fails++; $display("FAIL %s valid_drop beat%0d: got %b want 1", nm, nb, tb_valid);
        drop = 1;
        break;
      end
      if (r) begin
        vecs++;
        if (tb_x !== CL'(ex_x[nb]) || tb_y !== CL'(ex_y[nb]) || tb_op !== 2'(ex_op[nb]) ||
            tb_last !== (nb == ex_x.size() - 1)) begin
          fails++;
          $display("FAIL %s beat%0d: got x%0d y%0d op%0d last%0d want x%0d y%0d op%0d last%0d",
                   nm, nb, tb_x, tb_y, tb_op, tb_last, ex_x[nb], ex_y[nb], ex_op[nb],
                   (nb == ex_x.size() - 1));
        end
        nb++; held = 0; wcnt = 0;
      end else begin
        held = 1; wcnt++;
        hx = tb_x; hy = tb_y; hop = tb_op; hl = tb_last;
      end
      @(negedge clk); guard++;
    end
    tb_ready = 1'b0;
    if (guard >= 2000) begin fails++; $display("FAIL %s timeout: got %0d beats want %0d", nm, nb, ex_x.size()); end
    if (!drop) begin
      vecs++;
      if (tb_valid !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL %s end_state: got valid%b busy%b want 0 0", nm, tb_valid, busy);
      end
    end
  endtask

  task automatic check_zero(input string nm);
    vecs++;
    if ({busy, err, score, score_valid, tb_valid, tb_x, tb_y, tb_op, tb_last} !== '0) begin
      fails++;
      $display("FAIL %s outputs: got busy%b err%b score%0d sv%b v%b x%0d y%0d op%0d last%b want all 0",
               nm, busy, err, score, score_valid, tb_valid, tb_x, tb_y, tb_op, tb_last);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; tb_ready = 1'b0;
    len1 = '0; len2 = '0; s1 = '0; s2 = '0; match = '0; mismatch = '0; indel = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_directed;
    run_case("ac_ac", 2, 2, enc("AC"), enc("AC"), 1, -1, -1, 0, 0);
    vecs++;
    if (score !== 16'sd2) begin fails++; $display("FAIL ac_ac const_score: got %0d want 2", score); end
    run_case("agt_at", 3, 2, enc("AGT"), enc("AT"), 1, -1, -1, 0, 0);
    vecs++;
    if (score !== 16'sd1) begin fails++; $display("FAIL agt_at const_score: got %0d want 1", score); end
    run_case("agt_at_stall", 3, 2, enc("AGT"), enc("AT"), 1, -1, -1, 1, 0);
    run_case("a_c", 1, 1, enc("A"), enc("C"), 2, -3, -2, 0, 0);
    vecs++;
    if (score !== -16'sd3) begin fails++; $display("FAIL a_c const_score: got %0d want -3", score); end
    run_case("aaa_a", 3, 1, enc("AAA"), enc("A"), 1, -1, -1, 0, 0);
    vecs++;
    if (score !== -16'sd1) begin fails++; $display("FAIL aaa_a const_score: got %0d want -1", score); end
    run_case("max_len", ML, ML, SB'($urandom), SB'($urandom), 2, -1, -2, 2, 0);
  endtask

  task automatic test_err;
    int bad1[2] = '{0, 2};
    int bad2[2] = '{2, ML + 1};
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      drive_start(bad1[t], bad2[t], enc("AC"), enc("AC"), 1, -1, -1);
      @(negedge clk);
      start = 1'b0;
      vecs++;
      if (err !== 1'b1 || busy !== 1'b0 || score_valid !== 1'b1) begin
        fails++; $display("FAIL err%0d pulse: got err%b busy%b sv%b want 1 0 1", t, err, busy, score_valid);
      end
      @(negedge clk);
      vecs++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL err%0d clear: got err%b busy%b want 0 0", t, err, busy);
      end
    end
  endtask

  task automatic test_reset_mid;
    int w;
    @(negedge clk);
    drive_start(4, 4, SB'($urandom), SB'($urandom), 1, -1, -1);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("reset_fill");
    reset = 1'b0;
    @(negedge clk);
    drive_start(2, 2, enc("AC"), enc("AC"), 1, -1, -1);
    @(negedge clk); start = 1'b0;
    w = 0;
    while (!tb_valid && w < 100) begin @(negedge clk); w++; end
    vecs++;
    if (tb_valid !== 1'b1) begin fails++; $display("FAIL reset_trace reach: got %b want 1", tb_valid); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("reset_trace");
    reset = 1'b0;
    tb_ready = 1'b1;
    @(negedge clk);
    vecs++;
    if (tb_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_trace after: got v%b busy%b want 0 0", tb_valid, busy);
    end
    tb_ready = 1'b0;
    run_case("after_reset", 2, 2, enc("AC"), enc("AC"), 1, -1, -1, 0, 0);
  endtask

  task automatic test_back_to_back;
    run_case("b2b_a", 3, 5, SB'($urandom), SB'($urandom), 1, -1, -1, 0, 0);
    run_case("b2b_b", 5, 3, SB'($urandom), SB'($urandom), 2, -2, -1, 0, 1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 25; n++)
      run_case($sformatf("rand%0d", n), $urandom_range(1, ML), $urandom_range(1, ML),
               SB'($urandom), SB'($urandom), int'($urandom_range(0, 6)) - 2,
               int'($urandom_range(0, 6)) - 4, int'($urandom_range(0, 5)) - 4,
               $urandom_range(0, 2), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
